// File: rtl/vga_frame_monitor.sv
// Per-frame VGA timing/content monitor: checks line geometry and
// folds active pixels into a rotate-XOR checksum at each vsync edge.
module vga_frame_monitor #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int RW        = 5,
    parameter int GW        = 6,
    parameter int BW        = 5,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          de,
    input  logic          vsync,
    input  logic [RW-1:0] red,
    input  logic [GW-1:0] green,
    input  logic [BW-1:0] blue,
    output logic          frame_done,
    output logic          frame_ok,
    output logic [31:0]   checksum,
    output logic [15:0]   line_count,
    output logic          len_err,
    output logic          frame_stable,
    output logic [15:0]   frame_count
);
    localparam int PW = $clog2(H_ACTIVE + 1) + 1;
    localparam int CW = RW + GW + BW;
    localparam logic [PW-1:0] H_EXP = PW'(H_ACTIVE);
    localparam logic [15:0]   V_EXP = 16'(V_ACTIVE);

    typedef enum logic {WAIT_SYNC, IN_FRAME} state_t;

    state_t        state_q;
    logic          vsync_q;
    logic          de_q;
    logic [PW-1:0] pix_q;
    logic [15:0]   line_q;
    logic          err_q;
    logic [31:0]   acc_q;
    logic          have_prev_q;
    logic          done_q;
    logic          ok_q;
    logic          len_err_q;
    logic          stable_q;
    logic [31:0]   ck_q;
    logic [15:0]   lines_q;
    logic [15:0]   fcnt_q;

    logic          boundary;
    logic [CW-1:0] pix_w;
    logic [31:0]   pix_x;
    logic          close;
    logic [31:0]   acc_d;
    logic [PW-1:0] pix_d;
    logic [15:0]   line_d;
    logic          err_d;
    logic          ok_d;
    logic          stable_d;

    assign pix_w    = {red, green, blue};
    assign pix_x    = 32'(pix_w);
    assign boundary = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // Next values double as the closing-frame totals on a boundary cycle,
    // where a pixel or falling de on that same cycle still belongs to it.
    always_comb begin
        acc_d = de ? ({acc_q[30:0], acc_q[31]} ^ pix_x) : acc_q;
        pix_d = pix_q;
        if (de && pix_q != '1)
            pix_d = pix_q + 1'b1;
        close  = de | de_q;
        line_d = line_q;
        if (close && line_q != 16'hFFFF)
            line_d = line_q + 16'd1;
        err_d    = err_q | (close && pix_d != H_EXP);
        ok_d     = !err_d && (line_d == V_EXP);
        stable_d = have_prev_q && (acc_d == ck_q);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            vsync_q     <= !VSYNC_POL;
            de_q        <= 1'b0;
            pix_q       <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            have_prev_q <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            len_err_q   <= 1'b0;
            stable_q    <= 1'b0;
            ck_q        <= '0;
            lines_q     <= '0;
            fcnt_q      <= '0;
        end else begin
            vsync_q <= vsync;
            done_q  <= 1'b0;
            unique case (state_q)
                WAIT_SYNC: begin
                    de_q <= 1'b0;
                    if (boundary) begin
                        state_q <= IN_FRAME;
                        acc_q   <= '0;
                        pix_q   <= '0;
                        line_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                IN_FRAME: begin
                    if (boundary) begin
                        ck_q        <= acc_d;
                        lines_q     <= line_d;
                        len_err_q   <= err_d;
                        ok_q        <= ok_d;
                        stable_q    <= stable_d;
                        fcnt_q      <= fcnt_q + 16'd1;
                        have_prev_q <= 1'b1;
                        done_q      <= 1'b1;
                        // An open run was closed here; don't end it again.
                        de_q        <= 1'b0;
                        acc_q       <= '0;
                        pix_q       <= '0;
                        line_q      <= '0;
                        err_q       <= 1'b0;
                    end else begin
                        de_q <= de;
                        if (de) begin
                            pix_q <= pix_d;
                            acc_q <= acc_d;
                        end else if (de_q) begin
                            line_q <= line_d;
                            err_q  <= err_d;
                            pix_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign frame_done   = done_q;
    assign frame_ok     = ok_q;
    assign checksum     = ck_q;
    assign line_count   = lines_q;
    assign len_err      = len_err_q;
    assign frame_stable = stable_q;
    assign frame_count  = fcnt_q;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: fixed frame table, corner sequences
// and random frames against a frame-level reference model.
module tb_vga_frame_monitor;
    logic        pclk = 1'b0;
    logic        reset;
    logic        de;
    logic        vsync;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        frame_done;
    logic        frame_ok;
    logic [31:0] checksum;
    logic [15:0] line_count;
    logic        len_err;
    logic        frame_stable;
    logic [15:0] frame_count;

    vga_frame_monitor #(
        .H_ACTIVE (4),
        .V_ACTIVE (3),
        .RW       (5),
        .GW       (6),
        .BW       (5),
        .VSYNC_POL(1'b1)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .de          (de),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .checksum    (checksum),
        .line_count  (line_count),
        .len_err     (len_err),
        .frame_stable(frame_stable),
        .frame_count (frame_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          nl;
        int          l0;
        int          l1;
        int          l2;
        int          mode;
        logic [31:0] ck;
        int          ln;
        bit          err;
        bit          ok;
        bit          stb;
        int          cnt;
    } vec_t;

    vec_t        tbl[6];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          armed;
    bit          have_prev;
    logic [31:0] prev_ck;
    int          fcount;
    logic [31:0] px_q[$];
    int          len_q[$];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        de = 0;
        red = 0;
        green = 0;
        blue = 0;
        repeat (n) tick();
    endtask

    task automatic set_px(input int mode);
        red = 0;
        green = 0;
        blue = 0;
        if (mode == 0) blue = 5'd1;
        if (mode == 2) begin
            red = 5'($urandom);
            green = 6'($urandom);
            blue = 5'($urandom);
        end
        px_q.push_back({16'h0, red, green, blue});
    endtask

    task automatic line(input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            de = 1;
            set_px(mode);
            tick();
        end
        len_q.push_back(len);
        idle(2);
    endtask

    task automatic frame(input int nl, input int l0, input int l1,
                         input int l2, input int mode);
        int lens[3];
        lens[0] = l0;
        lens[1] = l1;
        lens[2] = l2;
        idle(2);
        for (int i = 0; i < nl; i++) line(lens[i], mode);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ":done"}, 32'(frame_done), 0);
        chk({nm, ":ok"}, 32'(frame_ok), 0);
        chk({nm, ":ck"}, checksum, 0);
        chk({nm, ":lines"}, 32'(line_count), 0);
        chk({nm, ":len_err"}, 32'(len_err), 0);
        chk({nm, ":stable"}, 32'(frame_stable), 0);
        chk({nm, ":count"}, 32'(frame_count), 0);
    endtask

    task automatic bound(input string nm, input bit exp_done,
                         input bit open_run, input logic [31:0] eck,
                         input int eln, input bit eerr, input bit eok,
                         input bit estb, input int ecnt, input int hold);
        vsync = 1;
        de = open_run;
        red = 0;
        green = 0;
        blue = open_run ? 5'd1 : 5'd0;
        tick();
        chk({nm, ":done"}, 32'(frame_done), 32'(exp_done));
        if (exp_done) begin
            chk({nm, ":ck"}, checksum, eck);
            chk({nm, ":lines"}, 32'(line_count), 32'(eln));
            chk({nm, ":len_err"}, 32'(len_err), 32'(eerr));
            chk({nm, ":ok"}, 32'(frame_ok), 32'(eok));
            chk({nm, ":stable"}, 32'(frame_stable), 32'(estb));
            chk({nm, ":count"}, 32'(frame_count), 32'(ecnt[15:0]));
        end
        de = 0;
        blue = 0;
        for (int i = 1; i < hold; i++) begin
            tick();
            chk({nm, ":hold_done"}, 32'(frame_done), 0);
        end
        vsync = 0;
        tick();
        chk({nm, ":pulse_end"}, 32'(frame_done), 0);
        if (exp_done) begin
            chk({nm, ":ck_held"}, checksum, eck);
            prev_ck = eck;
            have_prev = 1;
            fcount++;
        end
        armed = 1;
        px_q.delete();
        len_q.delete();
    endtask

    task automatic model_bound(input string nm, input int hold);
        logic [31:0] a;
        bit          err;
        int          nl;
        a = 0;
        err = 0;
        foreach (px_q[i]) a = {a[30:0], a[31]} ^ px_q[i];
        foreach (len_q[i]) if (len_q[i] != 4) err = 1;
        nl = len_q.size();
        bound(nm, armed, 0, a, nl, err, !err && nl == 3,
              have_prev && a == prev_ck, fcount + 1, hold);
    endtask

    initial begin
        tbl[0] = '{3, 4, 4, 4, 0, 32'h00000FFF, 3, 0, 1, 0, 1};
        tbl[1] = '{3, 4, 4, 4, 0, 32'h00000FFF, 3, 0, 1, 1, 2};
        tbl[2] = '{3, 4, 5, 4, 0, 32'h00001FFF, 3, 1, 0, 0, 3};
        tbl[3] = '{2, 4, 4, 0, 0, 32'h000000FF, 2, 0, 0, 0, 4};
        tbl[4] = '{3, 4, 4, 4, 1, 32'h00000000, 3, 0, 1, 0, 5};
        tbl[5] = '{3, 4, 4, 4, 1, 32'h00000000, 3, 0, 1, 1, 6};

        armed = 0;
        have_prev = 0;
        prev_ck = 0;
        fcount = 0;
        reset = 1;
        vsync = 1;
        idle(2);
        chk_zero("reset");

        // vsync already active at release is the first (discarded) edge
        reset = 0;
        tick();
        chk("rst_release_edge:done", 32'(frame_done), 0);
        armed = 1;
        vsync = 0;

        for (int i = 0; i < 6; i++) begin
            frame(tbl[i].nl, tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].mode);
            bound($sformatf("tbl%0d", i), 1, 0, tbl[i].ck, tbl[i].ln,
                  tbl[i].err, tbl[i].ok, tbl[i].stb, tbl[i].cnt, 1);
        end

        idle(2);
        line(4, 0);
        line(4, 0);
        for (int i = 0; i < 3; i++) begin
            de = 1;
            set_px(0);
            tick();
        end
        bound("open_run", 1, 1, 32'hFFF, 3, 0, 1, 0, 7, 1);
        frame(3, 4, 4, 4, 0);
        bound("after_open", 1, 0, 32'hFFF, 3, 0, 1, 1, 8, 1);

        idle(2);
        line(4, 0);
        de = 1;
        set_px(0);
        tick();
        tick();
        reset = 1;
        tick();
        chk_zero("mid_reset");
        reset = 0;
        idle(2);
        armed = 0;
        have_prev = 0;
        prev_ck = 0;
        fcount = 0;
        px_q.delete();
        len_q.delete();
        bound("post_rst_first", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        frame(3, 4, 4, 4, 0);
        bound("post_rst_second", 1, 0, 32'hFFF, 3, 0, 1, 0, 1, 1);

        for (int f = 0; f < 25; f++) begin
            int nl;
            int mode;
            nl = $urandom_range(2, 4);
            mode = $urandom_range(0, 2);
            idle($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : 4;
                line(len, mode);
            end
            model_bound($sformatf("rand%0d", f), $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
